tlb_replacer: RTL and testbench

TLB_REPLACER -- requirements
Module: tlb_replacer

---
 rtl/tlb_replacer_pkg.sv | 68 ++++++
 rtl/tlb_replacer_if.sv | 26 ++
 rtl/tlb_replacer.sv | 82 ++++++++
 tb/tb_tlb_replacer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tlb_replacer_pkg.sv
// Shared Sv32 types for the TLB refill walker: widths, PTE layout, TLB entry and FSM encodings.
package tlb_replacer_pkg;

   localparam int VPN_W   = 20;
   localparam int PPN_W   = 22;
   localparam int PADDR_W = 34;
   localparam int PTE_W   = 32;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_READ_L1 = 2'd1;
   localparam logic [1:0] ST_READ_L0 = 2'd2;
   localparam logic [1:0] ST_WRITE   = 2'd3;

   // Field order fixes the PTE bit positions: V=0 R=1 W=2 X=3 U=4 G=5 A=6 D=7 PPN=31:10.
   typedef struct packed {
      logic [PPN_W-1:0] ppn;
      logic [1:0]       rsw;
      logic             d;
      logic             a;
      logic             g;
      logic             u;
      logic             x;
      logic             w;
      logic             r;
      logic             v;
   } pte_t;

   typedef struct packed {
      logic dirty;
      logic user;
      logic execute;
      logic write;
      logic read;
   } tlb_flags_t;

   typedef struct packed {
      logic             valid;
      logic             fault;
      logic [PPN_W-1:0] page_number;
      tlb_flags_t       flags;
   } tlb_entry_t;

   typedef struct packed {
      logic       descend;
      tlb_entry_t entry;
   } pte_result_t;

   function automatic pte_result_t check_pte(input pte_t pte, input logic level1,
                                             input logic [VPN_W-1:0] vpn);
      pte_result_t res;
      res             = '0;
      res.entry.valid = 1'b1;
      if (!pte.v || (!pte.r && pte.w)) begin
         res.entry.fault = 1'b1;
      end else if (!pte.r && !pte.x) begin
         if (level1) res.descend = 1'b1;
         else        res.entry.fault = 1'b1;
      end else if (!pte.a || (level1 && pte.ppn[9:0] != 10'd0)) begin
         res.entry.fault = 1'b1;
      end else begin
         res.entry.page_number = level1 ? {pte.ppn[21:10], vpn[9:0]} : pte.ppn;
         res.entry.flags       = '{dirty: pte.d, user: pte.u, execute: pte.x,
                                   write: pte.w, read: pte.r};
      end
      return res;
   endfunction

endpackage

// File: rtl/tlb_replacer_if.sv
// Miss request, PTE memory read and TLB write port of the refill walker.
interface tlb_replacer_if;
   import tlb_replacer_pkg::*;

   logic               missValid;
   logic               missReady;
   logic [VPN_W-1:0]   missVirtualPageNumber;
   logic [PPN_W-1:0]   satpPageNumber;
   logic               memReadEnable;
   logic [PADDR_W-1:0] memAddr;
   logic               memReadDone;
   logic [PTE_W-1:0]   memReadValue;
   logic               tlbWriteEnable;
   logic [VPN_W-1:0]   tlbWriteKey;
   tlb_entry_t         tlbWriteValue;

   modport master (
      output missValid, missVirtualPageNumber, satpPageNumber, memReadDone, memReadValue,
      input  missReady, memReadEnable, memAddr, tlbWriteEnable, tlbWriteKey, tlbWriteValue
   );

   modport slave (
      input  missValid, missVirtualPageNumber, satpPageNumber, memReadDone, memReadValue,
      output missReady, memReadEnable, memAddr, tlbWriteEnable, tlbWriteKey, tlbWriteValue
   );
endinterface

// File: rtl/tlb_replacer.sv
// Two-level Sv32 page-table walker: accepts a TLB miss, reads up to two PTEs and writes one entry.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | waiting for a miss, missReady=1
// ST_READ_L1 | reading the level-1 PTE from the root table
// ST_READ_L0 | reading the level-0 PTE from the pointed-to table
// ST_WRITE   | one-cycle TLB write pulse
module tlb_replacer
   import tlb_replacer_pkg::*;
(
   input  logic         clk,
   input  logic         rstN,
   tlb_replacer_if.slave bus
);

   logic [1:0]       state;
   logic [VPN_W-1:0] vpn_q;
   logic [PPN_W-1:0] root_q;
   logic [PPN_W-1:0] next_ppn_q;
   tlb_entry_t       entry_q;
   pte_result_t      pte_res;
   pte_t             pte_in;

   assign pte_in  = pte_t'(bus.memReadValue);
   assign pte_res = check_pte(pte_in, state == ST_READ_L1, vpn_q);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state      <= ST_IDLE;
         vpn_q      <= '0;
         root_q     <= '0;
         next_ppn_q <= '0;
         entry_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.missValid) begin
                  vpn_q  <= bus.missVirtualPageNumber;
                  root_q <= bus.satpPageNumber;
                  state  <= ST_READ_L1;
               end
            end
            ST_READ_L1: begin
               if (bus.memReadDone) begin
                  if (pte_res.descend) begin
                     next_ppn_q <= pte_in.ppn;
                     state      <= ST_READ_L0;
                  end else begin
                     entry_q <= pte_res.entry;
                     state   <= ST_WRITE;
                  end
               end
            end
            ST_READ_L0: begin
               if (bus.memReadDone) begin
                  entry_q <= pte_res.entry;
                  state   <= ST_WRITE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.missReady      = (state == ST_IDLE);
   assign bus.memReadEnable  = (state == ST_READ_L1) || (state == ST_READ_L0);
   assign bus.tlbWriteEnable = (state == ST_WRITE);
   // Key/value are zeroed outside the write pulse so reset and idle look identical on the bus.
   assign bus.tlbWriteKey    = (state == ST_WRITE) ? vpn_q : '0;
   assign bus.tlbWriteValue  = (state == ST_WRITE) ? entry_q : '0;

   always_comb begin
      bus.memAddr = '0;
      case (state)
         ST_READ_L1: bus.memAddr = {root_q, vpn_q[19:10], 2'b00};
         ST_READ_L0: bus.memAddr = {next_ppn_q, vpn_q[9:0], 2'b00};
         default:    bus.memAddr = '0;
      endcase
   end

endmodule

// File: tb/tb_tlb_replacer.sv
// Self-checking bench for tlb_replacer: directed walks plus randomized walks against an arithmetic model.
module tb_tlb_replacer;
   logic clk;
   logic rstN;
   int   checks;
   int   failures;

   tlb_replacer_if bus();

   tlb_replacer dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Walk outcome computed straight from the page-table rules on integer fields.
   function automatic void ref_walk(input logic [19:0] vpn, input logic [21:0] satp,
                                    input logic [31:0] p1, input logic [31:0] p2,
                                    output int nreads, output logic [63:0] a1,
                                    output logic [63:0] a2, output logic [63:0] ent);
      logic [31:0] pte;
      logic [63:0] ppn;
      bit          fault;
      bit          done;
      a1 = (64'(satp) << 12) + (64'(vpn >> 10) << 2);
      a2 = (64'(p1 >> 10) << 12) + (64'(vpn % 20'd1024) << 2);
      nreads = 0;
      ent    = 64'd0;
      fault  = 0;
      done   = 0;
      for (int lvl = 1; lvl >= 0 && !done; lvl--) begin
         pte = (lvl == 1) ? p1 : p2;
         nreads++;
         if (!pte[0] || (!pte[1] && pte[2])) begin
            fault = 1; done = 1;
         end else if (!pte[1] && !pte[3]) begin
            if (lvl == 0) begin fault = 1; done = 1; end
         end else begin
            done = 1;
            if (!pte[6]) fault = 1;
            else if (lvl == 1 && ((pte >> 10) % 1024) != 0) fault = 1;
            else begin
               ppn = (lvl == 1) ? ((64'(pte >> 20) << 10) + 64'(vpn % 20'd1024))
                                : 64'(pte >> 10);
               ent = (64'd1 << 28) | (ppn << 5) |
                     64'({pte[7], pte[4], pte[3], pte[2], pte[1]});
            end
         end
      end
      if (fault) ent = 64'd3 << 27;
   endfunction

   function automatic logic [31:0] rand_pte();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 5))
         0, 5: r = (r & ~32'h0000_000E) | 32'h1;
         1: begin
            r = r | 32'h43;
            if ($urandom_range(0, 1) == 1) r = r & ~32'h000F_FC00;
         end
         2: begin
            r = (r & ~32'h0000_0006) | 32'h49;
            if ($urandom_range(0, 1) == 1) r = r & ~32'h000F_FC00;
         end
         3: r = r;
         default: r = r & ~32'h1;
      endcase
      return r;
   endfunction

   // Drives one miss from the current negedge, serves its reads, checks the write; ends one
   // cycle after the write pulse with missReady expected high.
   task automatic do_miss(input string tag, input logic [19:0] vpn, input logic [21:0] satp,
                          input logic [31:0] p1, input logic [31:0] p2,
                          input int w1, input int w2, input bit hold);
      int          nreads;
      logic [63:0] a1, a2, ent, exp_addr;
      logic [31:0] pv;
      int          wt;
      ref_walk(vpn, satp, p1, p2, nreads, a1, a2, ent);
      bus.missValid             = 1'b1;
      bus.missVirtualPageNumber = vpn;
      bus.satpPageNumber        = satp;
      chk({tag, ".accept_ready"}, 64'(bus.missReady), 64'd1);
      @(negedge clk);
      if (!hold) bus.missValid = 1'b0;
      bus.missVirtualPageNumber = 20'($urandom);
      bus.satpPageNumber        = 22'($urandom);
      for (int i = 0; i < nreads; i++) begin
         wt       = (i == 0) ? w1 : w2;
         exp_addr = (i == 0) ? a1 : a2;
         pv       = (i == 0) ? p1 : p2;
         for (int k = 0; k <= wt; k++) begin
            chk({tag, ".rd_en"}, 64'(bus.memReadEnable), 64'd1);
            chk({tag, ".rd_addr"}, 64'(bus.memAddr), exp_addr);
            chk({tag, ".no_early_write"}, 64'(bus.tlbWriteEnable), 64'd0);
            chk({tag, ".busy"}, 64'(bus.missReady), 64'd0);
            if (k == wt) begin
               bus.memReadDone  = 1'b1;
               bus.memReadValue = pv;
            end
            @(negedge clk);
            bus.memReadDone  = 1'b0;
            bus.memReadValue = $urandom;
         end
      end
      chk({tag, ".wr_en"}, 64'(bus.tlbWriteEnable), 64'd1);
      chk({tag, ".wr_key"}, 64'(bus.tlbWriteKey), 64'(vpn));
      chk({tag, ".wr_value"}, 64'(bus.tlbWriteValue), ent);
      chk({tag, ".wr_no_read"}, 64'(bus.memReadEnable), 64'd0);
      chk({tag, ".wr_busy"}, 64'(bus.missReady), 64'd0);
      @(negedge clk);
      chk({tag, ".wr_pulse_end"}, 64'(bus.tlbWriteEnable), 64'd0);
      chk({tag, ".ready_again"}, 64'(bus.missReady), 64'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".ready"}, 64'(bus.missReady), 64'd1);
      chk({tag, ".rd_en"}, 64'(bus.memReadEnable), 64'd0);
      chk({tag, ".wr_en"}, 64'(bus.tlbWriteEnable), 64'd0);
      chk({tag, ".addr"}, 64'(bus.memAddr), 64'd0);
      chk({tag, ".key"}, 64'(bus.tlbWriteKey), 64'd0);
      chk({tag, ".value"}, 64'(bus.tlbWriteValue), 64'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rstN     = 1'b0;
      bus.missValid             = 1'b0;
      bus.missVirtualPageNumber = '0;
      bus.satpPageNumber        = '0;
      bus.memReadDone           = 1'b0;
      bus.memReadValue          = '0;
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      do_miss("two_level", 20'h12345, 22'h00080, 32'h0002_0401, 32'h048C_00C7, 0, 0, 0);
      do_miss("superpage", 20'h12345, 22'h00080, 32'h0010_004B, 32'h0, 0, 0, 0);
      do_miss("superpage_misaligned", 20'h12345, 22'h00080, 32'h0010_044B, 32'h0, 0, 0, 0);
      do_miss("invalid", 20'h12345, 22'h00080, 32'h0000_0000, 32'h0, 0, 0, 0);
      do_miss("wait_states", 20'h0ABCD, 22'h3F001, 32'h0002_0401, 32'h048C_00C7, 5, 5, 0);

      // A done pulse with no read outstanding must not start anything.
      bus.memReadDone  = 1'b1;
      bus.memReadValue = 32'h048C_00C7;
      @(negedge clk);
      bus.memReadDone  = 1'b0;
      chk("idle_stray_done.wr_en", 64'(bus.tlbWriteEnable), 64'd0);
      chk("idle_stray_done.rd_en", 64'(bus.memReadEnable), 64'd0);

      // Reset while the level-0 read is outstanding, then a late done.
      bus.missValid             = 1'b1;
      bus.missVirtualPageNumber = 20'h12345;
      bus.satpPageNumber        = 22'h00080;
      @(negedge clk);
      bus.missValid    = 1'b0;
      bus.memReadDone  = 1'b1;
      bus.memReadValue = 32'h0002_0401;
      @(negedge clk);
      bus.memReadDone  = 1'b0;
      chk("mid_walk.l0_addr", 64'(bus.memAddr), 64'h81D14);
      rstN = 1'b0;
      #1;
      chk_reset_outputs("mid_walk_reset");
      @(negedge clk);
      rstN             = 1'b1;
      bus.memReadDone  = 1'b1;
      bus.memReadValue = 32'h048C_00C7;
      @(negedge clk);
      bus.memReadDone  = 1'b0;
      chk("after_reset.wr_en", 64'(bus.tlbWriteEnable), 64'd0);
      chk("after_reset.ready", 64'(bus.missReady), 64'd1);
      @(negedge clk);
      chk("after_reset.wr_en2", 64'(bus.tlbWriteEnable), 64'd0);
      do_miss("walk_after_reset", 20'h12345, 22'h00080, 32'h0002_0401, 32'h048C_00C7, 0, 1, 0);

      do_miss("b2b_first", 20'h00401, 22'h00011, 32'h0010_004B, 32'h0, 0, 0, 1);
      do_miss("b2b_second", 20'hFFFFF, 22'h3FFFF, 32'h0002_0401, 32'h048C_00C7, 0, 0, 1);
      do_miss("b2b_third", 20'h00000, 22'h00000, 32'h0000_0000, 32'h0, 1, 0, 0);

      for (int n = 0; n < 40; n++) begin
         do_miss("random", 20'($urandom), 22'($urandom), rand_pte(), rand_pte(),
                 $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      end
      bus.missValid = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
